// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if
//   Bundles the requester-side command/completion signals and the I2C master
//   engine signals that surround i2c_txn_arbiter.
//   slave  : view used by the arbiter (requests and master status in, grant,
//            completion and master command out).
//   master : view used by the surrounding clients/master model (mirror image).
interface i2c_txn_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
);
    // requester side
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [6*NREQ-1:0] req_nbyte;
    logic [7*NREQ-1:0] req_dev;
    logic [8*NREQ-1:0] req_ptr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   cmp_strobe;
    logic [7:0]        cmp_rdata;
    logic              cmp_err;
    logic [IDX_W-1:0]  grant_id;
    logic              busy;
    // I2C master engine side
    logic              m_go;
    logic              m_rw;
    logic [5:0]        m_nbyte;
    logic [6:0]        m_dev;
    logic [7:0]        m_ptr;
    logic [7:0]        m_dwr;
    logic              m_abort;
    logic [7:0]        m_drd;
    logic              m_ack_e;
    logic              m_done;

    modport slave (
        input  req, req_rw, req_nbyte, req_dev, req_ptr, req_wdata,
        input  m_drd, m_ack_e, m_done,
        output cmp_strobe, cmp_rdata, cmp_err, grant_id, busy,
        output m_go, m_rw, m_nbyte, m_dev, m_ptr, m_dwr, m_abort
    );

    modport master (
        output req, req_rw, req_nbyte, req_dev, req_ptr, req_wdata,
        output m_drd, m_ack_e, m_done,
        input  cmp_strobe, cmp_rdata, cmp_err, grant_id, busy,
        input  m_go, m_rw, m_nbyte, m_dev, m_ptr, m_dwr, m_abort
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Round-robin arbiter sharing one I2C master engine between NREQ requesters.
//   Latches the winner's command, pulses m_go until the master reports busy
//   (m_done low), waits for m_done high, and returns read byte / ack error with
//   a one-cycle one-hot cmp_strobe. A watchdog aborts hung transactions.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : i2c_txn_arbiter_if.slave (requester and master-engine signals)
module i2c_txn_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned IDX_W       = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    i2c_txn_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_COMPLETE} state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant_id;
    logic             r_busy;
    logic             r_go;
    logic             r_rw;
    logic [5:0]       r_nbyte;
    logic [6:0]       r_dev;
    logic [7:0]       r_ptr;
    logic [7:0]       r_dwr;
    logic             r_abort;
    logic [NREQ-1:0]  r_cmp_strobe;
    logic [7:0]       r_cmp_rdata;
    logic             r_cmp_err;
    logic [15:0]      r_wdog;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_sel_rw;
    logic [5:0]       w_sel_nbyte;
    logic [6:0]       w_sel_dev;
    logic [7:0]       w_sel_ptr;
    logic [7:0]       w_grant_wdata;

    // Round robin: first pass takes the lowest set bit at/above r_rr_ptr; the
    // second pass only matters when nothing was found there (wrap-around).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[i] && (IDX_W'(i) >= r_rr_ptr)) begin
                w_found = 1'b1;
                w_win   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[i]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(i);
            end
        end
    end

    // Slice selection for the candidate winner and the live wdata of the grantee.
    always_comb begin
        w_sel_rw      = 1'b0;
        w_sel_nbyte   = '0;
        w_sel_dev     = '0;
        w_sel_ptr     = '0;
        w_grant_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == w_win) begin
                w_sel_rw    = bus.req_rw[i];
                w_sel_nbyte = bus.req_nbyte[6*i +: 6];
                w_sel_dev   = bus.req_dev[7*i +: 7];
                w_sel_ptr   = bus.req_ptr[8*i +: 8];
            end
            if (IDX_W'(i) == r_grant_id) begin
                w_grant_wdata = bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_go         <= 1'b0;
            r_rw         <= 1'b0;
            r_nbyte      <= '0;
            r_dev        <= '0;
            r_ptr        <= '0;
            r_dwr        <= '0;
            r_abort      <= 1'b0;
            r_cmp_strobe <= '0;
            r_cmp_rdata  <= '0;
            r_cmp_err    <= 1'b0;
            r_wdog       <= '0;
        end else begin
            if (r_busy) begin
                r_dwr <= w_grant_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found && bus.m_done) begin
                        r_grant_id <= w_win;
                        r_rw       <= w_sel_rw;
                        r_nbyte    <= w_sel_nbyte;
                        r_dev      <= w_sel_dev;
                        r_ptr      <= w_sel_ptr;
                        r_busy     <= 1'b1;
                        r_go       <= 1'b1;
                        r_wdog     <= '0;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_BUSY: begin
                    // Watchdog spans both LAUNCH and BUSY; it wins over a
                    // same-cycle completion.
                    if (r_wdog == 16'(TIMEOUT_CYC)) begin
                        r_go         <= 1'b0;
                        r_abort      <= 1'b1;
                        r_cmp_err    <= 1'b1;
                        r_cmp_rdata  <= '0;
                        r_busy       <= 1'b0;
                        r_cmp_strobe <= ONE_HOT0 << r_grant_id;
                        r_state      <= S_COMPLETE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                        if (r_state == S_LAUNCH) begin
                            if (!bus.m_done) begin
                                r_go    <= 1'b0;
                                r_state <= S_BUSY;
                            end
                        end else if (bus.m_done) begin
                            r_cmp_rdata  <= bus.m_drd;
                            r_cmp_err    <= bus.m_ack_e;
                            r_busy       <= 1'b0;
                            r_cmp_strobe <= ONE_HOT0 << r_grant_id;
                            r_state      <= S_COMPLETE;
                        end
                    end
                end
                S_COMPLETE: begin
                    r_cmp_strobe <= '0;
                    r_abort      <= 1'b0;
                    r_wdog       <= '0;
                    r_rr_ptr     <= (r_grant_id == IDX_W'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmp_strobe = r_cmp_strobe;
    assign bus.cmp_rdata  = r_cmp_rdata;
    assign bus.cmp_err    = r_cmp_err;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = r_busy;
    assign bus.m_go       = r_go;
    assign bus.m_rw       = r_rw;
    assign bus.m_nbyte    = r_nbyte;
    assign bus.m_dev      = r_dev;
    assign bus.m_ptr      = r_ptr;
    assign bus.m_dwr      = r_dwr;
    assign bus.m_abort    = r_abort;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: table of directed transactions plus
// hand-written timeout, dropped-request and asynchronous-reset sequences.
module tb_i2c_txn_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned TCYC  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

    i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC), .IDX_W(IDX_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] cfg_dev   [NREQ] = '{7'h50, 7'h21, 7'h48, 7'h33};
    logic [7:0] cfg_ptr   [NREQ] = '{8'h80, 8'h7F, 8'h01, 8'hFE};
    logic [5:0] cfg_nbyte [NREQ] = '{6'd2, 6'd0, 6'd1, 6'd63};

    typedef struct {
        logic [3:0] mask;
        logic [3:0] rw;
        int         low;
        logic [7:0] drd;
        logic       ack;
        int         exp_g;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_dev[7*i +: 7]   = cfg_dev[i];
            bus.req_ptr[8*i +: 8]   = cfg_ptr[i];
            bus.req_nbyte[6*i +: 6] = cfg_nbyte[i];
            bus.req_wdata[8*i +: 8] = 8'h00;
        end
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.m_go === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_txn(input vec_t v, input bit drop_req, input string tag);
        bit         ok;
        int         g;
        logic [3:0] exp_strobe;
        logic [7:0] wd;
        g = v.exp_g;
        exp_strobe = 4'b0001 << g;
        bus.req    = v.mask;
        bus.req_rw = v.rw;
        wait_go(ok);
        chk({tag, " go_seen"}, 32'(ok), 32'd1);
        if (!ok) begin
            bus.req = '0;
            return;
        end
        chk({tag, " grant_id"}, 32'(bus.grant_id), 32'(g));
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " m_dev"}, 32'(bus.m_dev), 32'(cfg_dev[g]));
        chk({tag, " m_ptr"}, 32'(bus.m_ptr), 32'(cfg_ptr[g]));
        chk({tag, " m_nbyte"}, 32'(bus.m_nbyte), 32'(cfg_nbyte[g]));
        chk({tag, " m_rw"}, 32'(bus.m_rw), 32'(v.rw[g]));
        bus.m_done = 1'b0;
        if (drop_req) bus.req[g] = 1'b0;
        bus.req_dev[7*g +: 7] = ~cfg_dev[g];
        for (int k = 0; k < v.low; k++) begin
            wd = 8'(8'h30 + k + 16 * g);
            bus.req_wdata[8*g +: 8] = wd;
            tick();
            if (k == 0) begin
                chk({tag, " go_dropped"}, 32'(bus.m_go), 32'd0);
                chk({tag, " dev_frozen"}, 32'(bus.m_dev), 32'(cfg_dev[g]));
            end
            if (k < 3) chk({tag, " m_dwr"}, 32'(bus.m_dwr), 32'(wd));
        end
        bus.req_dev[7*g +: 7] = cfg_dev[g];
        bus.m_done  = 1'b1;
        bus.m_drd   = v.drd;
        bus.m_ack_e = v.ack;
        tick();
        chk({tag, " strobe"}, 32'(bus.cmp_strobe), 32'(exp_strobe));
        chk({tag, " rdata"}, 32'(bus.cmp_rdata), 32'(v.exp_rd));
        chk({tag, " err"}, 32'(bus.cmp_err), 32'(v.exp_err));
        chk({tag, " busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, " grant_hold"}, 32'(bus.grant_id), 32'(g));
        bus.m_drd   = 8'h00;
        bus.m_ack_e = 1'b0;
        bus.req     = '0;
        tick();
        chk({tag, " strobe_1cyc"}, 32'(bus.cmp_strobe), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        int cycles;
        bit seen;
        vec_t v;

        vecs[0]  = '{4'b0100, 4'b0000, 20, 8'h00, 1'b0, 2, 8'h00, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001,  5, 8'hA5, 1'b0, 0, 8'hA5, 1'b0};
        vecs[2]  = '{4'b1000, 4'b0000,  3, 8'h5C, 1'b0, 3, 8'h5C, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1010,  2, 8'h11, 1'b0, 0, 8'h11, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1010,  2, 8'h22, 1'b0, 1, 8'h22, 1'b0};
        vecs[5]  = '{4'b1111, 4'b1010,  2, 8'h33, 1'b0, 2, 8'h33, 1'b0};
        vecs[6]  = '{4'b1111, 4'b1010,  2, 8'h44, 1'b0, 3, 8'h44, 1'b0};
        vecs[7]  = '{4'b1111, 4'b1010,  2, 8'h55, 1'b0, 0, 8'h55, 1'b0};
        vecs[8]  = '{4'b0110, 4'b0010,  4, 8'h00, 1'b1, 1, 8'h00, 1'b1};
        vecs[9]  = '{4'b0111, 4'b0100,  2, 8'h7E, 1'b0, 2, 8'h7E, 1'b0};
        vecs[10] = '{4'b0011, 4'b0011,  1, 8'hC3, 1'b0, 0, 8'hC3, 1'b0};
        vecs[11] = '{4'b0001, 4'b0001,  1, 8'h3C, 1'b0, 0, 8'h3C, 1'b0};

        bus.req     = '0;
        bus.req_rw  = '0;
        bus.m_drd   = 8'h00;
        bus.m_ack_e = 1'b0;
        bus.m_done  = 1'b1;
        load_cfg();

        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst m_go", 32'(bus.m_go), 32'd0);
        chk("rst strobe", 32'(bus.cmp_strobe), 32'd0);
        chk("rst grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst m_abort", 32'(bus.m_abort), 32'd0);
        chk("rst m_dev", 32'(bus.m_dev), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Requester withdraws its request mid-transaction: strobe still issued.
        v = '{4'b1000, 4'b1000, 3, 8'h9D, 1'b0, 3, 8'h9D, 1'b0};
        run_txn(v, 1'b1, "drop_req");

        // Watchdog: master never finishes.
        bus.req = 4'b0010;
        wait_go(ok);
        chk("tmo go_seen", 32'(ok), 32'd1);
        bus.m_done = 1'b0;
        bus.m_drd  = 8'hFF;
        cycles = 0;
        seen   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            cycles++;
            if (bus.m_abort === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tmo abort_seen", 32'(seen), 32'd1);
        chk("tmo abort_cycle_in_99_101", 32'(cycles >= 99 && cycles <= 101), 32'd1);
        chk("tmo strobe", 32'(bus.cmp_strobe), 32'b0010);
        chk("tmo err", 32'(bus.cmp_err), 32'd1);
        chk("tmo rdata", 32'(bus.cmp_rdata), 32'd0);
        chk("tmo busy", 32'(bus.busy), 32'd0);
        bus.req    = '0;
        bus.m_done = 1'b1;
        bus.m_drd  = 8'h00;
        tick();
        chk("tmo abort_1cyc", 32'(bus.m_abort), 32'd0);
        chk("tmo strobe_1cyc", 32'(bus.cmp_strobe), 32'd0);

        // Asynchronous reset in the middle of BUSY.
        bus.req = 4'b0100;
        wait_go(ok);
        chk("arst go_seen", 32'(ok), 32'd1);
        bus.m_done = 1'b0;
        bus.req_wdata[8*2 +: 8] = 8'h6B;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst m_go", 32'(bus.m_go), 32'd0);
        chk("arst grant_id", 32'(bus.grant_id), 32'd0);
        chk("arst m_dev", 32'(bus.m_dev), 32'd0);
        chk("arst m_dwr", 32'(bus.m_dwr), 32'd0);
        chk("arst strobe", 32'(bus.cmp_strobe), 32'd0);
        bus.req    = '0;
        bus.m_done = 1'b1;
        load_cfg();
        tick();
        rst_n = 1'b1;
        tick();
        v = '{4'b0010, 4'b0010, 2, 8'hE7, 1'b0, 1, 8'hE7, 1'b0};
        run_txn(v, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
